writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/writeback_regfile_pkg.sv | 9 +
 rtl/writeback_regfile_if.sv | 32 +++
 rtl/writeback_regfile_reg_array.sv | 31 +++
 rtl/writeback_regfile.sv | 53 +++++
 tb/tb_writeback_regfile.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/writeback_regfile_pkg.sv
// wb_pkg: shared widths, link-write constants and zero-register index for the write-back register file
package wb_pkg;
    localparam int DATA_W = 32;
    localparam int NREG = 32;
    localparam int REG_ADDR_W = 5;
    localparam int LINK_REG = 31;
    localparam int LINK_OFFSET = 4;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/writeback_regfile_if.sv
// writeback_regfile_if: MEM/WB write-back inputs, decode read ports and forwarding outputs
interface writeback_regfile_if #(
    parameter int DATA_W = wb_pkg::DATA_W
);
    import wb_pkg::*;
    logic                  RegWrite;
    logic                  MemToReg;
    logic [DATA_W-1:0]     MemReadData;
    logic [DATA_W-1:0]     ALUResult;
    logic [REG_ADDR_W-1:0] WriteRegister;
    logic                  movIn;
    logic                  jumpIn;
    logic [DATA_W-1:0]     PCAddress;
    logic [REG_ADDR_W-1:0] ReadRegister1;
    logic [REG_ADDR_W-1:0] ReadRegister2;
    logic [DATA_W-1:0]     ReadData1;
    logic [DATA_W-1:0]     ReadData2;
    logic                  WBEnable;
    logic [REG_ADDR_W-1:0] WBRegister;
    logic [DATA_W-1:0]     WBData;
    logic [31:0]           WriteCount;
    modport master (
        output RegWrite, MemToReg, MemReadData, ALUResult, WriteRegister,
               movIn, jumpIn, PCAddress, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2, WBEnable, WBRegister, WBData, WriteCount
    );
    modport slave (
        input  RegWrite, MemToReg, MemReadData, ALUResult, WriteRegister,
               movIn, jumpIn, PCAddress, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2, WBEnable, WBRegister, WBData, WriteCount
    );
endinterface

// File: rtl/writeback_regfile_reg_array.sv
// reg_array: NREG x DATA_W storage, one write port, two async read ports, async active-low clear
module reg_array #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int NREG = wb_pkg::NREG
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          we_i,
    input  logic [wb_pkg::REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]             wdata_i,
    input  logic [wb_pkg::REG_ADDR_W-1:0] raddr1_i,
    input  logic [wb_pkg::REG_ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0]             rdata1_o,
    output logic [DATA_W-1:0]             rdata2_o
);
    import wb_pkg::*;
    logic [DATA_W-1:0] mem_q [NREG];
    // Commit one register per edge; index 0 is never stored
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else if (we_i && waddr_i != ZERO_REG) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end
    // Asynchronous reads with register 0 hardwired to zero
    always_comb begin
        rdata1_o = (raddr1_i == ZERO_REG) ? '0 : mem_q[raddr1_i];
        rdata2_o = (raddr2_i == ZERO_REG) ? '0 : mem_q[raddr2_i];
    end
endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: write-back data select, register file with write-through bypass, commit counter
module writeback_regfile #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int NREG = wb_pkg::NREG,
    parameter int LINK_REG = wb_pkg::LINK_REG,
    parameter int LINK_OFFSET = wb_pkg::LINK_OFFSET
) (
    input logic               Clk,
    input logic               Rst_n,
    writeback_regfile_if.slave bus
);
    import wb_pkg::*;
    logic [REG_ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0]     wb_data;
    logic                  wb_en;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [31:0]           count_q;
    logic [31:0]           count_d;
    // Link writes override destination and data; writes aimed at register 0 are dropped
    always_comb begin
        wb_reg = bus.jumpIn ? REG_ADDR_W'(LINK_REG) : bus.WriteRegister;
        wb_data = bus.jumpIn ? bus.PCAddress + DATA_W'(LINK_OFFSET)
                : (bus.movIn || !bus.MemToReg) ? bus.ALUResult : bus.MemReadData;
        wb_en = (bus.RegWrite || bus.jumpIn) && wb_reg != ZERO_REG;
        count_d = count_q + 32'd1;
    end
    // Count committed writes, wrapping naturally at 2^32
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) count_q <= '0;
        else if (wb_en) count_q <= count_d;
    end
    reg_array #(.DATA_W(DATA_W), .NREG(NREG)) u_regs (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .we_i    (wb_en),
        .waddr_i (wb_reg),
        .wdata_i (wb_data),
        .raddr1_i(bus.ReadRegister1),
        .raddr2_i(bus.ReadRegister2),
        .rdata1_o(rd1),
        .rdata2_o(rd2)
    );
    // Write-through bypass so decode sees the value committing this cycle; reads are zero in reset
    always_comb begin
        bus.ReadData1 = !Rst_n ? '0 : (wb_en && bus.ReadRegister1 == wb_reg) ? wb_data : rd1;
        bus.ReadData2 = !Rst_n ? '0 : (wb_en && bus.ReadRegister2 == wb_reg) ? wb_data : rd2;
    end
    assign bus.WBEnable = wb_en;
    assign bus.WBRegister = wb_reg;
    assign bus.WBData = wb_data;
    assign bus.WriteCount = count_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed and random checks against an array-based register file model
module tb_writeback_regfile;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] model_regs [32];
    logic [31:0] model_count = 0;

    writeback_regfile_if bus ();
    writeback_regfile dut (.Clk(clk), .Rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [4:0] exp_reg();
        return bus.jumpIn ? 5'd31 : bus.WriteRegister;
    endfunction

    function automatic logic [31:0] exp_data();
        if (bus.jumpIn) return bus.PCAddress + 32'd4;
        if (bus.movIn) return bus.ALUResult;
        return bus.MemToReg ? bus.MemReadData : bus.ALUResult;
    endfunction

    function automatic logic exp_en();
        return (bus.RegWrite || bus.jumpIn) && exp_reg() != 5'd0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'd0;
        if (exp_en() && a == exp_reg()) return exp_data();
        return model_regs[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".WBEnable"}, {31'd0, bus.WBEnable}, {31'd0, exp_en()});
        chk({tag, ".WBRegister"}, {27'd0, bus.WBRegister}, {27'd0, exp_reg()});
        chk({tag, ".WBData"}, bus.WBData, exp_data());
        chk({tag, ".ReadData1"}, bus.ReadData1, exp_read(bus.ReadRegister1));
        chk({tag, ".ReadData2"}, bus.ReadData2, exp_read(bus.ReadRegister2));
        chk({tag, ".WriteCount"}, bus.WriteCount, model_count);
    endtask

    task automatic idle();
        bus.RegWrite = 0; bus.MemToReg = 0; bus.MemReadData = 0; bus.ALUResult = 0;
        bus.WriteRegister = 0; bus.movIn = 0; bus.jumpIn = 0; bus.PCAddress = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && exp_en()) begin
            model_regs[exp_reg()] = exp_data();
            model_count = model_count + 32'd1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = 0;
        model_count = 0;
    endtask

    initial begin
        idle();
        bus.ReadRegister1 = 0; bus.ReadRegister2 = 0;
        apply_reset();
        #12;
        bus.ReadRegister1 = 5'd3; bus.ReadRegister2 = 5'd31;
        #1 check_all("reset");
        @(negedge clk); rst_n = 1'b1; #1;

        bus.RegWrite = 1; bus.ALUResult = 32'h0000_00AA; bus.WriteRegister = 5'd5;
        bus.MemReadData = 32'hDEAD_BEEF;
        tick();
        idle();
        bus.ReadRegister1 = 5'd5; bus.ReadRegister2 = 5'd5;
        #1 check_all("alu_write");
        chk("reg5", bus.ReadData1, 32'h0000_00AA);
        chk("count1", bus.WriteCount, 32'd1);

        bus.RegWrite = 1; bus.MemToReg = 1; bus.MemReadData = 32'h1234_5678; bus.WriteRegister = 5'd9;
        bus.ReadRegister1 = 5'd9; bus.ReadRegister2 = 5'd9;
        #1 check_all("bypass");
        chk("bypass_rd1", bus.ReadData1, 32'h1234_5678);
        chk("bypass_rd2", bus.ReadData2, 32'h1234_5678);
        tick();

        idle();
        bus.jumpIn = 1; bus.PCAddress = 32'h0040_0010; bus.WriteRegister = 5'd7;
        bus.ReadRegister1 = 5'd31; bus.ReadRegister2 = 5'd7;
        #1 check_all("jal_pre");
        tick();
        idle();
        #1 check_all("jal_post");
        chk("jal_r31", bus.ReadData1, 32'h0040_0014);
        chk("jal_r7", bus.ReadData2, 32'd0);

        bus.RegWrite = 1; bus.WriteRegister = 5'd0; bus.ALUResult = 32'hFFFF_FFFF;
        bus.ReadRegister1 = 5'd0; bus.ReadRegister2 = 5'd0;
        #1 check_all("r0_pre");
        chk("r0_en", {31'd0, bus.WBEnable}, 32'd0);
        tick();
        #1 check_all("r0_post");
        chk("r0_count", bus.WriteCount, 32'd3);

        force dut.count_q = 32'hFFFF_FFFF;
        #1 release dut.count_q;
        model_count = 32'hFFFF_FFFF;
        bus.RegWrite = 1; bus.MemToReg = 0; bus.movIn = 1; bus.MemReadData = 32'h5555_5555;
        bus.ALUResult = 32'hCAFE_F00D; bus.WriteRegister = 5'd12;
        #1 check_all("wrap_pre");
        tick();
        idle();
        chk("wrap_count", bus.WriteCount, 32'd0);

        bus.RegWrite = 1; bus.ALUResult = 32'h0BAD_0BAD; bus.WriteRegister = 5'd20;
        #2 apply_reset();
        #1;
        for (int i = 0; i < 32; i++) begin
            bus.ReadRegister1 = 5'(i); bus.ReadRegister2 = 5'(31 - i);
            #0.1 chk("rst_rd1", bus.ReadData1, 32'd0);
            chk("rst_rd2", bus.ReadData2, 32'd0);
        end
        chk("rst_count", bus.WriteCount, 32'd0);
        tick();
        bus.ReadRegister1 = 5'd20;
        #1 check_all("rst_hold");
        #1 rst_n = 1'b1;
        #1 check_all("rst_release");
        tick();
        idle();
        #1 check_all("first_commit");
        chk("first_r20", bus.ReadData1, 32'h0BAD_0BAD);

        for (int n = 0; n < 400; n++) begin
            bus.RegWrite = 1'($urandom_range(0, 3) != 0);
            bus.MemToReg = 1'($urandom);
            bus.movIn = 1'($urandom_range(0, 4) == 0);
            bus.jumpIn = 1'($urandom_range(0, 7) == 0);
            bus.MemReadData = $urandom;
            bus.ALUResult = $urandom;
            bus.PCAddress = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            bus.WriteRegister = 5'($urandom);
            bus.ReadRegister1 = ($urandom_range(0, 2) == 0) ? exp_reg() : 5'($urandom);
            bus.ReadRegister2 = ($urandom_range(0, 2) == 0) ? bus.ReadRegister1 : 5'($urandom);
            #1 check_all("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
